instr_fetch_unit: RTL and testbench

- Fetch stage. Drives the PC into the combinational instruction memory (`instruction_mem`: PC in, Instr out, same cycle).
- Captures each returned word and its address into a small in-order prefetch queue.
- Hands entries to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump) by flushing the queue and restarting fetch at the new address.

---
 rtl/instr_fetch_unit.sv | 78 +++++++
 tb/tb_instr_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the PC into a combinational instruction memory, buffers
// returned words in an in-order prefetch queue and hands them to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          pop;
    logic          push;

    // Handshake: an entry transfers on any edge where out_valid and out_ready
    // are both high; out_valid never depends on out_ready.
    assign pop  = out_valid & out_ready;
    assign push = ~redirect_valid & ((count < CW'(DEPTH)) | pop);

    assign imem_pc      = fetch_pc;
    assign out_valid    = (count != '0);
    assign out_pc       = out_valid ? pc_q[head] : '0;
    assign out_instr    = out_valid ? instr_q[head] : '0;
    assign out_pc_plus4 = out_valid ? pc_q[head] + 32'd4 : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            // A pop in this cycle is still accepted; the flush discards the rest.
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            if (push) begin
                pc_q[tail]    <= fetch_pc;
                instr_q[tail] <= imem_instr;
                tail          <= tail + PW'(1);
                fetch_pc      <= fetch_pc + 32'd4;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed test-plan steps followed by random
// traffic, all checked against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [31:0] m_pc;
    logic        m_mis;

    always #5 clk = ~clk;

    // Memory contents: mem[i] = A000_0000 + i, word indexed
    assign imem_instr = 32'hA000_0000 + (imem_pc >> 2);

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .imem_pc(imem_pc),
        .imem_instr(imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4),
        .misalign_err(misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("imem_pc", imem_pc, m_pc);
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
        if (exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0]);
            chk("out_instr", out_instr, 32'hA000_0000 + (exp_q[0] >> 2));
            chk("out_pc_plus4", out_pc_plus4, exp_q[0] + 32'd4);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc  = 32'h0000_0000;
        m_mis = 1'b0;
    endtask

    // One clock: drive inputs, check pre-edge outputs, advance model at the edge.
    task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic do_pop;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
        model_check();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            do_pop = (exp_q.size() != 0) && rdy;
            if (do_pop) void'(exp_q.pop_front());
            if (rv) begin
                exp_q.delete();
                m_pc = {rpc[31:2], 2'b00};
                if (rpc[1:0] != 2'b00) m_mis = 1'b1;
            end else if (exp_q.size() < DEPTH) begin
                exp_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_imem_pc", imem_pc, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_plus4", out_pc_plus4, 32'h0);
        chk("rst_mis", 32'(misalign_err), 32'd0);

        // Streaming
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            chk("stream_pc", out_pc, 32'(i * 4));
            chk("stream_instr", out_instr, 32'hA000_0000 + 32'(i));
        end

        // Backpressure
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b0);
        chk("bp_imem_pc", imem_pc, 32'h8);
        chk("bp_out_pc", out_pc, 32'h0);
        for (int i = 1; i < 4; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1);
            chk("bp_release_pc", out_pc, 32'(i * 4));
        end

        // Redirect with full queue
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 1'b0);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_imem_pc", imem_pc, 32'h40);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("redir_out_pc", out_pc, 32'h40);
        chk("redir_out_instr", out_instr, 32'hA000_0010);

        // Misaligned redirect, sticky through aligned ones
        cycle(1'b0, 1'b1, 32'h46, 1'b1);
        chk("mis_imem_pc", imem_pc, 32'h44);
        chk("mis_flag", 32'(misalign_err), 32'd1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("mis_sticky", 32'(misalign_err), 32'd1);

        // Back-to-back redirects: last wins
        cycle(1'b0, 1'b1, 32'h200, 1'b1);
        cycle(1'b0, 1'b1, 32'h300, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("b2b_out_pc", out_pc, 32'h300);

        // Wrap-around
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", out_pc_plus4, 32'h0);
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("wrap_pc1", out_pc, 32'h0);

        // Reset priority over redirect with full queue
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 32'h46, 1'b0);
        chk("rp_valid", 32'(out_valid), 32'd0);
        chk("rp_imem_pc", imem_pc, 32'h0);
        chk("rp_mis", 32'(misalign_err), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic        r_rst;
            logic        r_rv;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 63) == 0);
            r_rv  = ($urandom_range(0, 7) == 0);
            r_pc  = $urandom();
            if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
            cycle(r_rst, r_rv, r_pc, 1'($urandom_range(0, 1)));
        end
        cycle(1'b0, 1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
